// File: rtl/slot_spin_ctrl_pkg.sv
// Shared types and constants for the slot reel/credit sequencer and its SPI decoder.
package slot_pkg;

  localparam int REEL_IDX_W = 4;
  localparam int CREDIT_W   = 12;

  localparam logic [3:0] REQ_SPIN   = 4'h1;
  localparam logic [3:0] REQ_WIN    = 4'h2;
  localparam logic [3:0] REQ_UPDATE = 4'h3;

  typedef enum logic [1:0] {IDLE, SPIN, SHOW_WIN, ACK} spin_state_t;

  typedef logic [REEL_IDX_W-1:0] reel_idx_t;
  typedef logic [CREDIT_W-1:0]   credit_t;

  function automatic reel_idx_t clamp_idx(input reel_idx_t idx, input int unsigned num_sym);
    return (32'(idx) >= num_sym) ? reel_idx_t'(num_sym - 1) : idx;
  endfunction

endpackage

// File: rtl/slot_spin_ctrl_if.sv
// Request/display bundle between the SPI decoder (master) and the sequencer (slave).
interface slot_spin_ctrl_if;
  import slot_pkg::*;

  logic       start_spin;
  reel_idx_t  reel1_idx, reel2_idx, reel3_idx;
  logic       is_win;
  credit_t    win_credits;
  logic       is_total;
  credit_t    total_credits;

  reel_idx_t  reel1_pos, reel2_pos, reel3_pos;
  logic [2:0] reel_moving;
  logic       win_valid;
  credit_t    win_value;
  credit_t    credits_disp;
  logic       busy;
  logic       done;

  modport master (
    output start_spin, reel1_idx, reel2_idx, reel3_idx, is_win, win_credits,
           is_total, total_credits,
    input  reel1_pos, reel2_pos, reel3_pos, reel_moving, win_valid, win_value,
           credits_disp, busy, done
  );

  modport slave (
    input  start_spin, reel1_idx, reel2_idx, reel3_idx, is_win, win_credits,
           is_total, total_credits,
    output reel1_pos, reel2_pos, reel3_pos, reel_moving, win_valid, win_value,
           credits_disp, busy, done
  );

endinterface

// File: rtl/slot_spin_ctrl_tick_gen.sv
// Step-rate divider: tick_o on the last of every TICK_DIV enabled cycles; clr_i restarts the count.
module slot_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/slot_spin_ctrl.sv
// Reel spin / win display / credit sequencer with one shared done ack.
// Build option SLOT_WIN_BLINK_EN: win_valid toggles every step during the win hold.
module slot_spin_ctrl
  import slot_pkg::*;
#(
  parameter int TICK_DIV      = 250000,
  parameter int NUM_SYMBOLS   = 16,
  parameter int MIN_STEPS     = 32,
  parameter int STAGGER_STEPS = 8,
  parameter int WIN_HOLD      = 40
) (
  input logic            clk,
  input logic            reset,
  slot_spin_ctrl_if.slave bus
);

  spin_state_t state_q, state_d;
  logic [7:0]  step_q, step_d, step_nx;
  logic [7:0]  last_stop_q, last_stop_d;
  logic [2:0]  moving_q, moving_d;
  logic        pend_q, pend_d;
  credit_t     win_val_q, win_val_d;
  credit_t     cred_q, cred_d;
  logic [1:0]  tot_q, tot_d;
  logic        tick, spin_tick, start_go;
  logic [2:0]  stop_now;
  logic [2:0][REEL_IDX_W-1:0] idx_in, pos_w;

  assign idx_in    = {bus.reel3_idx, bus.reel2_idx, bus.reel1_idx};
  assign step_nx   = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
  assign spin_tick = tick && (state_q == SPIN);

  slot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_d != state_q),
    .en_i   ((state_q == SPIN) || (state_q == SHOW_WIN)),
    .tick_o (tick)
  );

  // Reels stop strictly in order, so the most recent stop step always belongs to reel k-1.
  for (genvar k = 0; k < 3; k++) begin : g_reel
    reel_idx_t pos_q, tgt_q, pos_nx;
    logic      elig;

    assign pos_nx = (pos_q == reel_idx_t'(NUM_SYMBOLS - 1)) ? '0 : pos_q + reel_idx_t'(1);
    if (k == 0) begin : g_first
      assign elig = (step_nx >= 8'(MIN_STEPS));
    end else begin : g_next
      assign elig = !moving_q[k-1] &&
                    ({1'b0, step_nx} >= ({1'b0, last_stop_q} + 9'(STAGGER_STEPS)));
    end
    assign stop_now[k] = spin_tick && moving_q[k] && elig && (pos_nx == tgt_q);
    assign pos_w[k]    = pos_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pos_q <= '0;
        tgt_q <= '0;
      end else begin
        if (start_go)                   tgt_q <= clamp_idx(idx_in[k], NUM_SYMBOLS);
        if (spin_tick && moving_q[k])   pos_q <= pos_nx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    last_stop_d = last_stop_q;
    moving_d    = moving_q;
    pend_d      = pend_q;
    win_val_d   = win_val_q;
    cred_d      = bus.is_total ? bus.total_credits : cred_q;
    tot_d       = {tot_q[0], bus.is_total};
    start_go    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_spin) begin
          start_go = 1'b1;
          state_d  = SPIN;
          step_d   = '0;
          moving_d = 3'b111;
        end else if (bus.is_win) begin
          state_d = SHOW_WIN;
        end
      end
      SPIN: begin
        if (tick) begin
          step_d   = step_nx;
          moving_d = moving_q & ~stop_now;
          if (|stop_now) last_stop_d = step_nx;
          if (stop_now[2]) state_d = pend_q ? SHOW_WIN : ACK;
        end
      end
      SHOW_WIN: begin
        if (tick) begin
          step_d = step_nx;
          if (step_nx == 8'(WIN_HOLD)) state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.is_win) begin
      win_val_d = bus.win_credits;
      if ((state_q != IDLE) || bus.start_spin) pend_d = 1'b1;
    end
    // Entering the display consumes the pending win and reuses step_q as the hold counter.
    if ((state_d == SHOW_WIN) && (state_q != SHOW_WIN)) begin
      pend_d = 1'b0;
      step_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      last_stop_q <= '0;
      moving_q    <= '0;
      pend_q      <= 1'b0;
      win_val_q   <= '0;
      cred_q      <= '0;
      tot_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      last_stop_q <= last_stop_d;
      moving_q    <= moving_d;
      pend_q      <= pend_d;
      win_val_q   <= win_val_d;
      cred_q      <= cred_d;
      tot_q       <= tot_d;
    end
  end

`ifdef SLOT_WIN_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (state_d != SHOW_WIN)      blink_d = 1'b0;
    else if (state_q != SHOW_WIN) blink_d = 1'b1;
    else if (tick)                blink_d = ~blink_q;
  end

  always_ff @(posedge clk) begin
    if (reset) blink_q <= 1'b0;
    else       blink_q <= blink_d;
  end

  assign bus.win_valid = blink_q;
`else
  assign bus.win_valid = (state_q == SHOW_WIN);
`endif

  assign bus.reel1_pos    = pos_w[0];
  assign bus.reel2_pos    = pos_w[1];
  assign bus.reel3_pos    = pos_w[2];
  assign bus.reel_moving  = moving_q;
  assign bus.win_value    = win_val_q;
  assign bus.credits_disp = cred_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == ACK) || tot_q[1];

endmodule

// File: tb/tb_slot_spin_ctrl.sv
// Bench for slot_spin_ctrl: event-level reference model compared every cycle plus directed literal checks.
module tb_slot_spin_ctrl;

  localparam int TD = 4, NS = 16, MS = 16, ST = 4, WH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slot_spin_ctrl_if ifa ();
  slot_spin_ctrl_if ifb ();

  slot_spin_ctrl #(.TICK_DIV(TD), .NUM_SYMBOLS(NS), .MIN_STEPS(MS),
                   .STAGGER_STEPS(ST), .WIN_HOLD(WH)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));

  slot_spin_ctrl #(.TICK_DIV(TD), .NUM_SYMBOLS(10), .MIN_STEPS(MS),
                   .STAGGER_STEPS(ST), .WIN_HOLD(WH)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [41:0] a_outs;
  assign a_outs = {ifa.reel3_pos, ifa.reel2_pos, ifa.reel1_pos, ifa.reel_moving, ifa.win_valid,
                   ifa.win_value, ifa.credits_disp, ifa.busy, ifa.done};

  // Reference model: modes 0 idle, 1 spin, 2 win display, 3 ack. Stop ticks solved arithmetically.
  int   cyc = 0, m_mode = 0, m_t0 = 0;
  int   m_sp[3], m_tg[3], m_stop[3], m_pos[3];
  bit   m_pend = 0, m_p1 = 0, m_p2 = 0, mvalid = 0;
  logic [11:0] m_wval = '0, m_cred = '0;

  function automatic int first_hit(input int sp, input int tg, input int from);
    int res = -1;
    int lo = (from < 1) ? 1 : from;
    for (int n = lo; n < lo + NS; n++)
      if (res < 0 && ((sp + n) % NS) == tg) res = n;
    return res;
  endfunction

  function automatic int clampi(input int v);
    return (v >= NS) ? NS - 1 : v;
  endfunction

  always @(posedge clk) begin
    int r;
    bit ent_win;
    r = cyc - m_t0 + 1;
    ent_win = 0;
    if (reset) begin
      m_mode = 0; m_pend = 0; m_p1 = 0; m_p2 = 0; m_wval = '0; m_cred = '0;
      for (int k = 0; k < 3; k++) m_pos[k] = 0;
      m_t0 = cyc + 1;
      mvalid = 1;
    end else begin
      m_p2 = m_p1;
      m_p1 = ifa.is_total;
      if (ifa.is_total) m_cred = ifa.total_credits;
      case (m_mode)
        0: begin
          if (ifa.start_spin) begin
            m_tg[0] = clampi(int'(ifa.reel1_idx));
            m_tg[1] = clampi(int'(ifa.reel2_idx));
            m_tg[2] = clampi(int'(ifa.reel3_idx));
            for (int k = 0; k < 3; k++) m_sp[k] = m_pos[k];
            m_stop[0] = first_hit(m_sp[0], m_tg[0], MS);
            m_stop[1] = first_hit(m_sp[1], m_tg[1], m_stop[0] + ST);
            m_stop[2] = first_hit(m_sp[2], m_tg[2], m_stop[1] + ST);
            m_mode = 1; m_t0 = cyc + 1;
            if (ifa.is_win) begin m_wval = ifa.win_credits; m_pend = 1; end
          end else if (ifa.is_win) begin
            m_wval = ifa.win_credits; m_pend = 0; m_mode = 2; m_t0 = cyc + 1;
          end
        end
        1: begin
          if (r == m_stop[2] * TD) begin
            for (int k = 0; k < 3; k++) m_pos[k] = m_tg[k];
            if (m_pend) begin m_mode = 2; ent_win = 1; end
            else m_mode = 3;
            m_t0 = cyc + 1;
          end
          if (ifa.is_win) begin m_wval = ifa.win_credits; m_pend = 1; end
          if (ent_win) m_pend = 0;
        end
        2: begin
          if (ifa.is_win) begin m_wval = ifa.win_credits; m_pend = 1; end
          if (r == WH * TD) begin m_mode = 3; m_t0 = cyc + 1; end
        end
        default: begin
          if (ifa.is_win) begin m_wval = ifa.win_credits; m_pend = 1; end
          m_mode = 0; m_t0 = cyc + 1;
        end
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    int n, e_pos[3];
    logic [2:0] e_mv;
    logic e_wv;
    if (mvalid) begin
      n = (cyc - m_t0) / TD;
      for (int k = 0; k < 3; k++) begin
        if (m_mode == 1) begin
          e_pos[k] = (m_sp[k] + ((n < m_stop[k]) ? n : m_stop[k])) % NS;
          e_mv[k]  = (n < m_stop[k]);
        end else begin
          e_pos[k] = m_pos[k];
          e_mv[k]  = 1'b0;
        end
      end
`ifdef SLOT_WIN_BLINK_EN
      e_wv = (m_mode == 2) && ((n % 2) == 0);
`else
      e_wv = (m_mode == 2);
`endif
      chk($sformatf("model_outputs_cyc%0d", cyc), {22'd0, a_outs},
          {22'd0, 4'(e_pos[2]), 4'(e_pos[1]), 4'(e_pos[0]), e_mv, e_wv, m_wval, m_cred,
           m_mode != 0, (m_mode == 3) || m_p2});
    end
  end

  int w_st[3];
  int w_done_at, w_done_n, w_wv_n, w_idle_at;

  task automatic watch(input int maxc);
    for (int k = 0; k < 3; k++) w_st[k] = -1;
    w_done_at = -1; w_done_n = 0; w_wv_n = 0; w_idle_at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (w_st[k] < 0 && !ifa.reel_moving[k]) w_st[k] = i;
      if (ifa.done) begin
        w_done_n++;
        if (w_done_at < 0) w_done_at = i;
      end
      if (ifa.win_valid) w_wv_n++;
      if (w_idle_at < 0 && !ifa.busy) w_idle_at = i;
    end
  endtask

  task automatic spin_a(input logic [3:0] t1, input logic [3:0] t2, input logic [3:0] t3);
    @(posedge clk); #1;
    ifa.start_spin = 1'b1;
    ifa.reel1_idx = t1; ifa.reel2_idx = t2; ifa.reel3_idx = t3;
    @(posedge clk); #1;
    ifa.start_spin = 1'b0;
  endtask

  task automatic total_seq(input logic [11:0] val, input logic [11:0] prev, input string tag);
    @(posedge clk); #1;
    ifa.is_total = 1'b1; ifa.total_credits = val;
    @(negedge clk);
    chk({tag, "_credits_before"}, ifa.credits_disp, prev);
    @(posedge clk); #1;
    ifa.is_total = 1'b0;
    @(negedge clk);
    chk({tag, "_credits_next"}, ifa.credits_disp, val);
    chk({tag, "_done_not_yet"}, ifa.done, 1'b0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, ifa.done, 1'b1);
    @(negedge clk);
    chk({tag, "_done_cleared"}, ifa.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    reset = 1'b1;
    ifa.start_spin = 0; ifa.reel1_idx = 0; ifa.reel2_idx = 0; ifa.reel3_idx = 0;
    ifa.is_win = 0; ifa.win_credits = 0; ifa.is_total = 0; ifa.total_credits = 0;
    ifb.start_spin = 0; ifb.reel1_idx = 0; ifb.reel2_idx = 0; ifb.reel3_idx = 0;
    ifb.is_win = 0; ifb.win_credits = 0; ifb.is_total = 0; ifb.total_credits = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", {22'd0, a_outs}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Spin 3/7/A from position 0: stops at ticks 19, 23, 42.
    spin_a(4'h3, 4'h7, 4'hA);
    chk("model_stop_reel1", m_stop[0], 19);
    chk("model_stop_reel2", m_stop[1], 23);
    chk("model_stop_reel3", m_stop[2], 42);
    watch(200);
    chk("t1_reel1_stop_cycle", w_st[0], 19 * TD);
    chk("t1_reel2_stop_cycle", w_st[1], 23 * TD);
    chk("t1_reel3_stop_cycle", w_st[2], 42 * TD);
    chk("t1_done_cycle", w_done_at, 42 * TD);
    chk("t1_done_count", w_done_n, 1);
    chk("t1_busy_drop_cycle", w_idle_at, 42 * TD + 1);
    chk("t1_positions", {ifa.reel3_pos, ifa.reel2_pos, ifa.reel1_pos}, 12'hA73);

    // Spin 0/0/0 with a win reported at tick 10.
    spin_a(4'h0, 4'h0, 4'h0);
    fork
      watch(320);
      begin
        repeat (40) @(posedge clk);
        #1; ifa.is_win = 1'b1; ifa.win_credits = 12'h064;
        @(posedge clk); #1; ifa.is_win = 1'b0;
      end
    join
`ifdef SLOT_WIN_BLINK_EN
    chk("t2_win_valid_cycles", w_wv_n, 16);
`else
    chk("t2_win_valid_cycles", w_wv_n, 32);
`endif
    chk("t2_win_value", ifa.win_value, 12'h064);
    chk("t2_done_count", w_done_n, 1);
    chk("t2_done_cycle", w_done_at, 54 * TD + 32);
    chk("t2_positions", {ifa.reel3_pos, ifa.reel2_pos, ifa.reel1_pos}, 12'h000);

    // Spin 1/2/3 with a stray start_spin F/F/F mid-spin.
    spin_a(4'h1, 4'h2, 4'h3);
    fork
      watch(260);
      begin
        repeat (20) @(posedge clk);
        #1; ifa.start_spin = 1'b1;
        ifa.reel1_idx = 4'hF; ifa.reel2_idx = 4'hF; ifa.reel3_idx = 4'hF;
        @(posedge clk); #1; ifa.start_spin = 1'b0;
      end
    join
    chk("t3_done_count", w_done_n, 1);
    chk("t3_reel3_stop_cycle", w_st[2], 51 * TD);
    chk("t3_positions", {ifa.reel3_pos, ifa.reel2_pos, ifa.reel1_pos}, 12'h321);

    // Credit update in IDLE, then during a spin.
    total_seq(12'h3E8, 12'h000, "t4_idle");
    spin_a(4'h5, 4'h5, 4'h5);
    repeat (9) @(posedge clk);
    total_seq(12'h123, 12'h3E8, "t4_spin");
    watch(250);
    chk("t4_spin_done_count", w_done_n, 1);
    chk("t4_positions", {ifa.reel3_pos, ifa.reel2_pos, ifa.reel1_pos}, 12'h555);

    // Clamp with 10 symbols.
    @(posedge clk); #1;
    ifb.start_spin = 1'b1; ifb.reel1_idx = 4'hC; ifb.reel2_idx = 4'hC; ifb.reel3_idx = 4'hC;
    @(posedge clk); #1;
    ifb.start_spin = 1'b0;
    bcnt = 0;
    do begin
      @(negedge clk);
      bcnt++;
    end while (ifb.busy && bcnt < 400);
    chk("t5_finished_in_time", bcnt < 400, 1'b1);
    chk("t5_positions", {ifb.reel3_pos, ifb.reel2_pos, ifb.reel1_pos}, 12'h999);

    // Reset at tick 20 of a spin, then a normal spin.
    spin_a(4'h8, 4'h8, 4'h8);
    repeat (80) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("t6_outputs_zero_after_reset", {22'd0, a_outs}, 64'd0);
    watch(40);
    chk("t6_no_done_after_reset", w_done_n, 0);
    spin_a(4'h3, 4'h7, 4'hA);
    watch(200);
    chk("t6_reel3_stop_cycle", w_st[2], 42 * TD);
    chk("t6_done_cycle", w_done_at, 42 * TD);
    chk("t6_positions", {ifa.reel3_pos, ifa.reel2_pos, ifa.reel1_pos}, 12'hA73);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
